// File: rtl/ser_arb_pkg.sv
// Shared types, constants and helpers for the serializer arbiter.
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Busy length implied by a length code of 0.
  localparam int FULL_LEN   = 16;
  // RUN-cycle count at which a still-busy serializer is declared hung.
  localparam int WDOG_LIMIT = 17;
  localparam int CNT_W      = 5;
  localparam int MOD_WIDTH  = 4;

  // Length codes the serializer silently ignores.
  localparam logic [MOD_WIDTH-1:0] MOD_ILL_A = 4'd1;
  localparam logic [MOD_WIDTH-1:0] MOD_ILL_B = 4'd2;

  function automatic logic mod_is_legal(input logic [MOD_WIDTH-1:0] m);
    return (m != MOD_ILL_A) && (m != MOD_ILL_B);
  endfunction

endpackage

// File: rtl/ser_arbiter_if.sv
// Requester and serializer bundle around ser_arbiter.
// slave = the arbiter's view, master = the surrounding requesters/serializer.
interface ser_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4,
  parameter int IDX_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_val_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*MOD_W-1:0]  req_mod_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]       ser_data_o;
  logic [MOD_W-1:0]        ser_mod_o;
  logic                    ser_val_o;
  logic                    ser_busy_i;
  logic [IDX_W-1:0]        grant_idx_o;
  logic                    grant_val_o;
  logic                    done_o;
  logic                    drop_o;
  logic [IDX_W-1:0]        drop_idx_o;
  logic                    err_o;

  modport slave (
    input  req_val_i, req_data_i, req_mod_i, ser_busy_i,
    output req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
           grant_idx_o, grant_val_o, done_o, drop_o, drop_idx_o, err_o
  );

  modport master (
    output req_val_i, req_data_i, req_mod_i, ser_busy_i,
    input  req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
           grant_idx_o, grant_val_o, done_o, drop_o, drop_idx_o, err_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // First valid requester after ptr wins; ptr itself is checked last.
  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter/sequencer feeding one shared serializer: screens
// illegal length codes, issues one load strobe per word and supervises busy.
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  ser_arbiter_if.slave bus
);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic [MOD_W-1:0]  mod_reg;
  logic [IDX_W-1:0]  grant_idx_reg;
  logic              drop_reg;
  logic [IDX_W-1:0]  drop_idx_reg;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] win_data;
  logic [MOD_W-1:0]  win_mod;
  logic              win_legal;

  logic              accept;
  logic [N_REQ-1:0]  ready;
  logic              done_now;
  logic              err_now;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req (bus.req_val_i),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign win_data  = bus.req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign win_mod   = bus.req_mod_i[int'(pick_idx)*MOD_W +: MOD_W];
  assign win_legal = mod_is_legal(win_mod);

  // Next state plus the combinational handshake and completion pulses.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ready      = '0;
    done_now   = 1'b0;
    err_now    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // Ready is held low while reset is asserted.
        if (rst_n_i && !bus.ser_busy_i && pick_any) begin
          accept = 1'b1;
          ready  = pick_gnt;
          if (win_legal) state_next = ISSUE;
        end
      end
      ISSUE: state_next = RUN;
      RUN: begin
        if (!bus.ser_busy_i) begin
          // Idle on the very first RUN cycle means the load was ignored.
          state_next = IDLE;
          if (cnt_reg == '0) err_now  = 1'b1;
          else               done_now = 1'b1;
        end else if (cnt_reg == CNT_W'(WDOG_LIMIT)) begin
          err_now    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, round-robin pointer (moves on every handshake) and watchdog count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      ptr_reg   <= IDX_W'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) ptr_reg <= pick_idx;
      if (state_reg == ISSUE)    cnt_reg <= '0;
      else if (state_reg == RUN) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Latch the accepted word for the serializer, or flag it as dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_reg      <= '0;
      mod_reg       <= '0;
      grant_idx_reg <= '0;
      drop_reg      <= 1'b0;
      drop_idx_reg  <= '0;
    end else begin
      drop_reg <= accept && !win_legal;
      if (accept && win_legal) begin
        data_reg      <= win_data;
        mod_reg       <= win_mod;
        grant_idx_reg <= pick_idx;
      end
      if (accept && !win_legal) drop_idx_reg <= pick_idx;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.ser_data_o  = data_reg;
  assign bus.ser_mod_o   = mod_reg;
  assign bus.ser_val_o   = (state_reg == ISSUE);
  assign bus.grant_idx_o = grant_idx_reg;
  assign bus.grant_val_o = (state_reg != IDLE);
  assign bus.done_o      = done_now;
  assign bus.drop_o      = drop_reg;
  assign bus.drop_idx_o  = drop_idx_reg;
  assign bus.err_o       = err_now;

endmodule

// File: tb/tb_ser_arbiter.sv
// Self-checking bench for ser_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level reference model.
module tb_ser_arbiter;
  import ser_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int IW = 2;

  typedef struct {
    int          cyc;
    int          idx;
    logic [15:0] data;
    logic [3:0]  mod;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ser_arbiter_if #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW), .IDX_W(IW)) bus ();

  ser_arbiter #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW), .IDX_W(IW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  // Pending words per requester, {mod, data}.
  logic [19:0] rq [N][$];

  // Serializer model: 0 normal, 1 ignores loads, 2 busy forever once loaded.
  int          ser_mode = 0;
  logic        ser_busy = 1'b0;
  int          ser_rem  = 0;
  logic [15:0] ser_sh   = '0;
  logic [15:0] ser_col  = '0;

  ev_t got_acc[$], got_sv[$], got_done[$], got_drop[$], got_err[$];
  ev_t exp_acc[$], exp_sv[$], exp_done[$], exp_drop[$], exp_err[$];
  logic [15:0] got_bits[$], exp_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic ev_t mk(input int c, input int i, input logic [15:0] d, input logic [3:0] m);
    ev_t e;
    e.cyc = c; e.idx = i; e.data = d; e.mod = m;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_val_i[i]           = 1'b1;
        bus.req_data_i[i*DW +: DW] = rq[i][0][15:0];
        bus.req_mod_i[i*MW +: MW]  = rq[i][0][19:16];
      end else begin
        bus.req_val_i[i]           = 1'b0;
        bus.req_data_i[i*DW +: DW] = '0;
        bus.req_mod_i[i*MW +: MW]  = '0;
      end
    end
    bus.ser_busy_i = ser_busy;
  endtask

  // One clock: sample at the falling edge, update environment after the rising edge.
  task automatic cycle();
    logic [N-1:0]  rdy;
    logic          sv;
    logic [DW-1:0] sd;
    logic [MW-1:0] sm;
    logic          busy_n;
    @(negedge clk);
    rdy = bus.req_ready_o; sv = bus.ser_val_o; sd = bus.ser_data_o; sm = bus.ser_mod_o;
    busy_n = ser_busy;
    if (rdy != '0) begin
      chk("ready_onehot", 32'($countones(rdy)), 32'd1);
      got_acc.push_back(mk(cyc_cnt, oh_idx(rdy), '0, '0));
      $display("cyc %0d: accept req %0d", cyc_cnt, oh_idx(rdy));
    end
    if (sv) begin
      chk("grant_val_in_issue", 32'(bus.grant_val_o), 32'd1);
      got_sv.push_back(mk(cyc_cnt, int'(bus.grant_idx_o), sd, sm));
      $display("cyc %0d: load owner %0d data=%h mod=%0d", cyc_cnt, bus.grant_idx_o, sd, sm);
    end
    if (bus.done_o) begin
      got_done.push_back(mk(cyc_cnt, int'(bus.grant_idx_o), '0, '0));
      $display("cyc %0d: done owner %0d", cyc_cnt, bus.grant_idx_o);
    end
    if (bus.drop_o) begin
      got_drop.push_back(mk(cyc_cnt, int'(bus.drop_idx_o), '0, '0));
      $display("cyc %0d: drop req %0d", cyc_cnt, bus.drop_idx_o);
    end
    if (bus.err_o) begin
      got_err.push_back(mk(cyc_cnt, int'(bus.grant_idx_o), '0, '0));
      $display("cyc %0d: err owner %0d", cyc_cnt, bus.grant_idx_o);
    end
    if (ser_busy) begin
      if (ser_mode != 2) begin
        ser_col = {ser_col[14:0], ser_sh[15]};
        ser_sh  = ser_sh << 1;
        ser_rem--;
        if (ser_rem == 0) begin
          busy_n = 1'b0;
          got_bits.push_back(ser_col);
        end
      end
    end else if (sv && ser_mode != 1) begin
      ser_sh  = sd;
      ser_col = '0;
      ser_rem = (sm == 0) ? FULL_LEN : int'(sm);
      busy_n  = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
    ser_busy = busy_n;
    for (int i = 0; i < N; i++)
      if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic run_until(input int t);
    while (cyc_cnt < t) cycle();
  endtask

  task automatic clear_logs();
    got_acc.delete(); got_sv.delete(); got_done.delete(); got_drop.delete(); got_err.delete();
    exp_acc.delete(); exp_sv.delete(); exp_done.delete(); exp_drop.delete(); exp_err.delete();
    got_bits.delete(); exp_bits.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    ser_busy = 1'b0;
    ser_mode = 0;
    drive();
    repeat (3) cycle();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"},     32'(bus.req_ready_o), 32'd0);
    chk({tag, "_ser_val"},   32'(bus.ser_val_o),   32'd0);
    chk({tag, "_ser_data"},  32'(bus.ser_data_o),  32'd0);
    chk({tag, "_ser_mod"},   32'(bus.ser_mod_o),   32'd0);
    chk({tag, "_grant_idx"}, 32'(bus.grant_idx_o), 32'd0);
    chk({tag, "_grant_val"}, 32'(bus.grant_val_o), 32'd0);
    chk({tag, "_done"},      32'(bus.done_o),      32'd0);
    chk({tag, "_drop"},      32'(bus.drop_o),      32'd0);
    chk({tag, "_drop_idx"},  32'(bus.drop_idx_o),  32'd0);
    chk({tag, "_err"},       32'(bus.err_o),       32'd0);
  endtask

  // Reference model: all queued words are pending from cycle 'start'.
  // Drops cost one cycle; legal words occupy L+3 cycles accept-to-accept.
  task automatic predict(input int start, output int end_t);
    logic [19:0] q [N][$];
    int ptr, t, w, len;
    logic [19:0] it;
    logic [3:0] m;
    bit pending;
    for (int i = 0; i < N; i++) q[i] = rq[i];
    ptr = N - 1;
    t = start;
    end_t = start;
    pending = 1'b1;
    while (pending) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && q[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
      if (w < 0) begin
        pending = 1'b0;
      end else begin
        ptr = w;
        it = q[w].pop_front();
        m = it[19:16];
        exp_acc.push_back(mk(t, w, '0, '0));
        if (m == 4'd1 || m == 4'd2) begin
          exp_drop.push_back(mk(t + 1, w, '0, '0));
          end_t = t + 1;
          t = t + 1;
        end else begin
          len = (m == 0) ? 16 : int'(m);
          exp_sv.push_back(mk(t + 1, w, it[15:0], m));
          exp_done.push_back(mk(t + len + 2, w, '0, '0));
          exp_bits.push_back(it[15:0] >> (16 - len));
          end_t = t + len + 2;
          t = t + len + 3;
        end
      end
    end
  endtask

  task automatic cmp_ev(input string tag, input ev_t g[$], input ev_t e[$], input bit with_data);
    chk({tag, "_count"}, 32'(g.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      chk($sformatf("%s[%0d]_cyc", tag, i), 32'(g[i].cyc), 32'(e[i].cyc));
      chk($sformatf("%s[%0d]_idx", tag, i), 32'(g[i].idx), 32'(e[i].idx));
      if (with_data) begin
        chk($sformatf("%s[%0d]_data", tag, i), 32'(g[i].data), 32'(e[i].data));
        chk($sformatf("%s[%0d]_mod", tag, i),  32'(g[i].mod),  32'(e[i].mod));
      end
    end
  endtask

  task automatic compare(input string tag);
    cmp_ev({tag, "_accept"}, got_acc,  exp_acc,  1'b0);
    cmp_ev({tag, "_load"},   got_sv,   exp_sv,   1'b1);
    cmp_ev({tag, "_done"},   got_done, exp_done, 1'b0);
    cmp_ev({tag, "_drop"},   got_drop, exp_drop, 1'b0);
    cmp_ev({tag, "_err"},    got_err,  exp_err,  1'b0);
    chk({tag, "_bits_count"}, 32'(got_bits.size()), 32'(exp_bits.size()));
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      chk($sformatf("%s_bits[%0d]", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
  endtask

  initial begin
    int s, r, e_end;
    int ord [5];
    logic [15:0] d;
    ord = '{0, 1, 2, 3, 0};
    bus.req_val_i = '0; bus.req_data_i = '0; bus.req_mod_i = '0; bus.ser_busy_i = 1'b0;

    // Reset state: outputs low, ready stays low even with every request valid.
    repeat (2) cycle();
    bus.req_val_i = '1;
    #1;
    chk_outputs_zero("reset");

    // Test 1: single requester, mod 0, then a follow-up word.
    do_reset();
    rq[0].push_back({4'd0, 16'hA5F0});
    rq[0].push_back({4'd5, 16'h1234});
    drive();
    s = cyc_cnt;
    run_until(s + 40);
    exp_acc.push_back(mk(s, 0, '0, '0));
    exp_acc.push_back(mk(s + 19, 0, '0, '0));
    exp_sv.push_back(mk(s + 1, 0, 16'hA5F0, 4'd0));
    exp_sv.push_back(mk(s + 20, 0, 16'h1234, 4'd5));
    exp_done.push_back(mk(s + 18, 0, '0, '0));
    exp_done.push_back(mk(s + 26, 0, '0, '0));
    exp_bits.push_back(16'hA5F0);
    exp_bits.push_back(16'h0002);
    compare("t1");

    // Test 2: all four valid with mod 4 -> 0,1,2,3,0 spaced 7 cycles.
    do_reset();
    for (int i = 0; i < N; i++) rq[i].push_back({4'd4, 16'($urandom)});
    rq[0].push_back({4'd4, 16'($urandom)});
    drive();
    s = cyc_cnt;
    predict(s, e_end);
    run_until(e_end + 4);
    compare("t2");
    for (int k = 0; k < 5 && k < got_acc.size(); k++) begin
      chk($sformatf("t2_order[%0d]", k), 32'(got_acc[k].idx), 32'(ord[k]));
      if (k > 0) chk($sformatf("t2_gap[%0d]", k), 32'(got_acc[k].cyc - got_acc[k-1].cyc), 32'd7);
    end

    // Test 3: pointer at 0, req1 illegal mod 2 dropped, req2 granted next cycle.
    do_reset();
    rq[0].push_back({4'd3, 16'($urandom)});
    rq[1].push_back({4'd2, 16'($urandom)});
    rq[2].push_back({4'd3, 16'($urandom)});
    drive();
    s = cyc_cnt;
    predict(s, e_end);
    run_until(e_end + 4);
    compare("t3");
    chk("t3_drop_count", 32'(got_drop.size()), 32'd1);
    if (got_acc.size() == 3) begin
      chk("t3_req2_idx", 32'(got_acc[2].idx), 32'd2);
      chk("t3_req2_next_cycle", 32'(got_acc[2].cyc - got_acc[1].cyc), 32'd1);
    end

    // Test 4: serializer ignores loads -> err one cycle after ISSUE, no done.
    do_reset();
    ser_mode = 1;
    rq[0].push_back({4'd4, 16'h1111});
    rq[0].push_back({4'd4, 16'h2222});
    drive();
    s = cyc_cnt;
    run_until(s + 10);
    exp_acc.push_back(mk(s, 0, '0, '0));
    exp_acc.push_back(mk(s + 3, 0, '0, '0));
    exp_sv.push_back(mk(s + 1, 0, 16'h1111, 4'd4));
    exp_sv.push_back(mk(s + 4, 0, 16'h2222, 4'd4));
    exp_err.push_back(mk(s + 2, 0, '0, '0));
    exp_err.push_back(mk(s + 5, 0, '0, '0));
    compare("t4");

    // Test 5: serializer stuck busy -> watchdog err, then resume once busy drops.
    do_reset();
    ser_mode = 2;
    rq[0].push_back({4'd4, 16'hBEEF});
    rq[1].push_back({4'd4, 16'hC3C3});
    drive();
    s = cyc_cnt;
    run_until(s + 30);
    ser_mode = 0;
    ser_busy = 1'b0;
    bus.ser_busy_i = 1'b0;
    r = cyc_cnt;
    run_until(r + 12);
    exp_acc.push_back(mk(s, 0, '0, '0));
    exp_acc.push_back(mk(r, 1, '0, '0));
    exp_sv.push_back(mk(s + 1, 0, 16'hBEEF, 4'd4));
    exp_sv.push_back(mk(r + 1, 1, 16'hC3C3, 4'd4));
    exp_err.push_back(mk(s + 2 + WDOG_LIMIT, 0, '0, '0));
    exp_done.push_back(mk(r + 6, 1, '0, '0));
    exp_bits.push_back(16'h000C);
    compare("t5");

    // Test 6: asynchronous reset mid-RUN, then requester 0 wins first.
    do_reset();
    rq[0].push_back({4'd0, 16'h5A5A});
    drive();
    s = cyc_cnt;
    run_until(s + 6);
    chk("t6_in_run", 32'(bus.grant_val_o), 32'd1);
    clear_logs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    ser_busy = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) rq[i].push_back({4'd3, 16'($urandom)});
    drive();
    s = cyc_cnt;
    run_until(s + 3);
    chk("t6_first_count", 32'(got_acc.size()), 32'd1);
    if (got_acc.size() > 0) begin
      chk("t6_first_idx", 32'(got_acc[0].idx), 32'd0);
      chk("t6_first_cyc", 32'(got_acc[0].cyc), 32'(s));
    end
    chk("t6_no_done", 32'(got_done.size()), 32'd0);
    chk("t6_no_err", 32'(got_err.size()), 32'd0);

    // Randomized rounds against the reference model, illegal codes included.
    for (int round = 0; round < 5; round++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int nw;
        nw = $urandom_range(0, 3);
        for (int j = 0; j < nw; j++) begin
          d = 16'($urandom);
          rq[i].push_back({4'($urandom_range(0, 15)), d});
        end
      end
      drive();
      s = cyc_cnt;
      predict(s, e_end);
      run_until(e_end + 5);
      compare($sformatf("rand%0d", round));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
